// File: rtl/usb_pkg.sv
// Shared types and constants for the USB bulk-endpoint transaction controller.
package usb_pkg;

  // PID classes reported by the receiver at end of packet
  localparam logic [3:0] PID_IN    = 4'b0001;
  localparam logic [3:0] PID_OUT   = 4'b0010;
  localparam logic [3:0] PID_ACK   = 4'b0100;
  localparam logic [3:0] PID_NAK   = 4'b1000;
  localparam logic [3:0] PID_OTHER = 4'b0000;

  // Packet the transmitter is told to send
  typedef enum logic [2:0] {
    TX_NONE  = 3'b000,
    TX_DATA  = 3'b001,
    TX_ACK   = 3'b010,
    TX_NAK   = 3'b011,
    TX_STALL = 3'b100
  } tx_packet_t;

  // Transaction controller states
  typedef enum logic [2:0] {
    IDLE,
    OUT_WAIT,
    TURN,
    TX_BUSY,
    IN_WAIT
  } state_t;

  localparam int TIMEOUT_CYCLES_DEFAULT    = 160;
  localparam int TURNAROUND_CYCLES_DEFAULT = 2;
  localparam int TIMER_W_DEFAULT           = 8;

endpackage

// File: rtl/usb_txn_ctrl_if.sv
// Receiver/transmitter/host signal bundle seen by the transaction controller.
interface usb_txn_ctrl_if;
  logic [3:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_transfer_active;
  logic       rx_error;
  logic [6:0] rx_buffer_occupancy;
  logic       tx_data_ready;
  logic       tx_transfer_active;
  logic       tx_error;
  logic       ep_halt;
  logic       tx_start;
  logic [2:0] tx_packet;
  logic       d_mode;
  logic       flush;
  logic       out_done;
  logic       in_done;
  logic       txn_error;

  // Controller side
  modport slave (
    input  rx_packet, rx_data_ready, rx_transfer_active, rx_error,
    input  rx_buffer_occupancy, tx_data_ready, tx_transfer_active,
    input  tx_error, ep_halt,
    output tx_start, tx_packet, d_mode, flush, out_done, in_done, txn_error
  );

  // Environment side (receiver, transmitter, host logic)
  modport master (
    output rx_packet, rx_data_ready, rx_transfer_active, rx_error,
    output rx_buffer_occupancy, tx_data_ready, tx_transfer_active,
    output tx_error, ep_halt,
    input  tx_start, tx_packet, d_mode, flush, out_done, in_done, txn_error
  );
endinterface

// File: rtl/usb_eop_detect.sv
// End-of-packet detector: flags the cycle in which the receiver's
// transfer-active indication falls.
module usb_eop_detect (
  input  logic clk,
  input  logic n_rst,
  input  logic active,
  output logic eop
);
  logic prev_active_reg;

  // Remember last cycle's transfer-active level
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) prev_active_reg <= 1'b0;
    else        prev_active_reg <= active;
  end

  assign eop = prev_active_reg & ~active;
endmodule

// File: rtl/usb_txn_ctrl.sv
// Device-side transaction controller for one bulk endpoint: chooses the
// handshake/data response, sequences the transmitter and RX buffer flush,
// and reports completed or abandoned transactions.
module usb_txn_ctrl
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES    = TIMEOUT_CYCLES_DEFAULT,
  parameter int TURNAROUND_CYCLES = TURNAROUND_CYCLES_DEFAULT,
  parameter int TIMER_W           = TIMER_W_DEFAULT
) (
  input logic           clk,
  input logic           n_rst,
  usb_txn_ctrl_if.slave bus
);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TURN_LAST    = TIMER_W'(TURNAROUND_CYCLES - 1);

  logic               eop;
  state_t             state_reg;
  tx_packet_t         pending_reg;
  tx_packet_t         tx_packet_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic               accept_reg;
  logic               tx_active_prev_reg;
  logic               tx_start_reg;
  logic               d_mode_reg;
  logic               flush_reg;
  logic               out_done_reg;
  logic               in_done_reg;
  logic               txn_error_reg;
  logic               tx_fall;

  usb_eop_detect u_eop_detect (
    .clk    (clk),
    .n_rst  (n_rst),
    .active (bus.rx_transfer_active),
    .eop    (eop)
  );

  // Transmitter completion is its falling transfer-active edge
  assign tx_fall = tx_active_prev_reg & ~bus.tx_transfer_active;

  // Transaction FSM with shared timeout/turnaround timer; all outputs registered
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg          <= IDLE;
      pending_reg        <= TX_NONE;
      tx_packet_reg      <= TX_NONE;
      timer_reg          <= '0;
      accept_reg         <= 1'b0;
      tx_active_prev_reg <= 1'b0;
      tx_start_reg       <= 1'b0;
      d_mode_reg         <= 1'b0;
      flush_reg          <= 1'b0;
      out_done_reg       <= 1'b0;
      in_done_reg        <= 1'b0;
      txn_error_reg      <= 1'b0;
    end else begin
      tx_start_reg       <= 1'b0;
      flush_reg          <= 1'b0;
      out_done_reg       <= 1'b0;
      in_done_reg        <= 1'b0;
      txn_error_reg      <= 1'b0;
      tx_active_prev_reg <= bus.tx_transfer_active;
      case (state_reg)
        IDLE: begin
          if (eop) begin
            if (bus.rx_error) begin
              txn_error_reg <= 1'b1;
            end else if (bus.rx_packet == PID_OUT) begin
              accept_reg <= (bus.rx_buffer_occupancy == 7'd0) && !bus.ep_halt;
              timer_reg  <= '0;
              state_reg  <= OUT_WAIT;
            end else if (bus.rx_packet == PID_IN) begin
              pending_reg <= bus.ep_halt ? TX_STALL :
                             (bus.tx_data_ready ? TX_DATA : TX_NAK);
              timer_reg   <= '0;
              state_reg   <= TURN;
            end
          end
        end
        OUT_WAIT: begin
          // A decisive eop takes priority over a coincident timeout
          if (eop && bus.rx_error) begin
            flush_reg     <= 1'b1;
            txn_error_reg <= 1'b1;
            state_reg     <= IDLE;
          end else if (eop && bus.rx_data_ready) begin
            if (bus.ep_halt) begin
              pending_reg <= TX_STALL;
              flush_reg   <= 1'b1;
            end else if (accept_reg) begin
              pending_reg <= TX_ACK;
            end else begin
              pending_reg <= TX_NAK;
              flush_reg   <= 1'b1;
            end
            timer_reg <= '0;
            state_reg <= TURN;
          end else if (timer_reg == TIMEOUT_LAST) begin
            flush_reg     <= 1'b1;
            txn_error_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        TURN: begin
          if (timer_reg == TURN_LAST) begin
            tx_packet_reg <= pending_reg;
            tx_start_reg  <= 1'b1;
            d_mode_reg    <= 1'b1;
            state_reg     <= TX_BUSY;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        TX_BUSY: begin
          if (bus.tx_error) begin
            d_mode_reg    <= 1'b0;
            tx_packet_reg <= TX_NONE;
            txn_error_reg <= 1'b1;
            state_reg     <= IDLE;
          end else if (tx_fall) begin
            d_mode_reg    <= 1'b0;
            tx_packet_reg <= TX_NONE;
            case (pending_reg)
              TX_ACK: begin
                out_done_reg <= 1'b1;
                state_reg    <= IDLE;
              end
              TX_DATA: begin
                timer_reg <= '0;
                state_reg <= IN_WAIT;
              end
              default: state_reg <= IDLE;
            endcase
          end
        end
        IN_WAIT: begin
          // Host data stays staged on any failure so it can be retried
          if (eop) begin
            if ((bus.rx_packet == PID_ACK) && !bus.rx_error) in_done_reg <= 1'b1;
            else                                             txn_error_reg <= 1'b1;
            state_reg <= IDLE;
          end else if (timer_reg == TIMEOUT_LAST) begin
            txn_error_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.tx_start  = tx_start_reg;
  assign bus.tx_packet = tx_packet_reg;
  assign bus.d_mode    = d_mode_reg;
  assign bus.flush     = flush_reg;
  assign bus.out_done  = out_done_reg;
  assign bus.in_done   = in_done_reg;
  assign bus.txn_error = txn_error_reg;
endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Directed bench for the USB transaction controller.
module tb_usb_txn_ctrl;
  logic clk;
  logic n_rst;
  int   compared;
  int   mismatched;

  usb_txn_ctrl_if bus ();

  usb_txn_ctrl #(
    .TIMEOUT_CYCLES    (160),
    .TURNAROUND_CYCLES (2),
    .TIMER_W           (8)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receiver packet: active for 3 cycles, then the eop cycle with its results
  task automatic send_pkt(input logic [3:0] pid, input logic dr, input logic err);
    bus.rx_transfer_active = 1'b1;
    repeat (3) tick();
    bus.rx_transfer_active = 1'b0;
    bus.rx_packet          = pid;
    bus.rx_data_ready      = dr;
    bus.rx_error           = err;
    tick();
    bus.rx_packet     = 4'b0000;
    bus.rx_data_ready = 1'b0;
    bus.rx_error      = 1'b0;
  endtask

  task automatic tx_end();
    bus.tx_transfer_active = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.rx_packet = 4'b0; bus.rx_data_ready = 1'b0; bus.rx_transfer_active = 1'b0;
    bus.rx_error = 1'b0; bus.rx_buffer_occupancy = 7'd0; bus.tx_data_ready = 1'b0;
    bus.tx_transfer_active = 1'b0; bus.tx_error = 1'b0; bus.ep_halt = 1'b0;
    repeat (3) tick();
    compared++; if (bus.tx_start !== 1'b0) begin mismatched++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
    compared++; if (bus.tx_packet !== 3'b000) begin mismatched++; $display("FAIL reset_tx_packet: got %b want 000", bus.tx_packet); end
    compared++; if (bus.d_mode !== 1'b0) begin mismatched++; $display("FAIL reset_d_mode: got %b want 0", bus.d_mode); end
    compared++; if (bus.flush !== 1'b0) begin mismatched++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
    compared++; if (bus.out_done !== 1'b0) begin mismatched++; $display("FAIL reset_out_done: got %b want 0", bus.out_done); end
    compared++; if (bus.in_done !== 1'b0) begin mismatched++; $display("FAIL reset_in_done: got %b want 0", bus.in_done); end
    compared++; if (bus.txn_error !== 1'b0) begin mismatched++; $display("FAIL reset_txn_error: got %b want 0", bus.txn_error); end
    n_rst = 1'b1;
    tick();
    $display("txn reset: outputs idle");
  endtask

  task automatic test_out_ack();
    bus.rx_buffer_occupancy = 7'd0; bus.ep_halt = 1'b0;
    send_pkt(4'b0010, 1'b0, 1'b0);
    repeat (2) tick();
    send_pkt(4'b0000, 1'b1, 1'b0);
    compared++; if (bus.flush !== 1'b0) begin mismatched++; $display("FAIL out_ack_flush: got %b want 0", bus.flush); end
    tick();
    compared++; if (bus.tx_start !== 1'b0) begin mismatched++; $display("FAIL out_ack_early_start: got %b want 0", bus.tx_start); end
    tick();
    compared++; if (bus.tx_start !== 1'b1) begin mismatched++; $display("FAIL out_ack_start: got %b want 1", bus.tx_start); end
    compared++; if (bus.tx_packet !== 3'b010) begin mismatched++; $display("FAIL out_ack_packet: got %b want 010", bus.tx_packet); end
    compared++; if (bus.d_mode !== 1'b1) begin mismatched++; $display("FAIL out_ack_d_mode: got %b want 1", bus.d_mode); end
    bus.tx_transfer_active = 1'b1;
    tick();
    compared++; if (bus.tx_start !== 1'b0) begin mismatched++; $display("FAIL out_ack_start_pulse: got %b want 0", bus.tx_start); end
    repeat (3) tick();
    compared++; if (bus.d_mode !== 1'b1 || bus.tx_packet !== 3'b010) begin mismatched++; $display("FAIL out_ack_busy_hold: got d_mode=%b pkt=%b want 1/010", bus.d_mode, bus.tx_packet); end
    tx_end();
    compared++; if (bus.d_mode !== 1'b0 || bus.tx_packet !== 3'b000) begin mismatched++; $display("FAIL out_ack_release: got d_mode=%b pkt=%b want 0/000", bus.d_mode, bus.tx_packet); end
    compared++; if (bus.out_done !== 1'b1) begin mismatched++; $display("FAIL out_ack_done: got %b want 1", bus.out_done); end
    tick();
    compared++; if (bus.out_done !== 1'b0) begin mismatched++; $display("FAIL out_ack_done_pulse: got %b want 0", bus.out_done); end
    $display("txn OUT occ=0: ACK sent, out_done");
  endtask

  task automatic test_out_nak();
    bus.rx_buffer_occupancy = 7'd12; bus.ep_halt = 1'b0;
    send_pkt(4'b0010, 1'b0, 1'b0);
    tick();
    send_pkt(4'b0000, 1'b1, 1'b0);
    compared++; if (bus.flush !== 1'b1) begin mismatched++; $display("FAIL out_nak_flush: got %b want 1", bus.flush); end
    tick();
    compared++; if (bus.flush !== 1'b0) begin mismatched++; $display("FAIL out_nak_flush_pulse: got %b want 0", bus.flush); end
    tick();
    compared++; if (bus.tx_start !== 1'b1 || bus.tx_packet !== 3'b011) begin mismatched++; $display("FAIL out_nak_start: got start=%b pkt=%b want 1/011", bus.tx_start, bus.tx_packet); end
    bus.tx_transfer_active = 1'b1;
    repeat (3) tick();
    tx_end();
    compared++; if (bus.out_done !== 1'b0 || bus.d_mode !== 1'b0) begin mismatched++; $display("FAIL out_nak_end: got out_done=%b d_mode=%b want 0/0", bus.out_done, bus.d_mode); end
    bus.rx_buffer_occupancy = 7'd0;
    $display("txn OUT occ=12: NAK sent, flushed");
  endtask

  task automatic test_in_data();
    bus.tx_data_ready = 1'b1; bus.ep_halt = 1'b0;
    send_pkt(4'b0001, 1'b0, 1'b0);
    repeat (2) tick();
    compared++; if (bus.tx_start !== 1'b1 || bus.tx_packet !== 3'b001) begin mismatched++; $display("FAIL in_data_start: got start=%b pkt=%b want 1/001", bus.tx_start, bus.tx_packet); end
    bus.tx_transfer_active = 1'b1;
    repeat (4) tick();
    tx_end();
    compared++; if (bus.d_mode !== 1'b0 || bus.in_done !== 1'b0) begin mismatched++; $display("FAIL in_data_end: got d_mode=%b in_done=%b want 0/0", bus.d_mode, bus.in_done); end
    send_pkt(4'b0100, 1'b0, 1'b0);
    compared++; if (bus.in_done !== 1'b1 || bus.txn_error !== 1'b0) begin mismatched++; $display("FAIL in_data_ack: got in_done=%b txn_error=%b want 1/0", bus.in_done, bus.txn_error); end
    tick();
    compared++; if (bus.in_done !== 1'b0) begin mismatched++; $display("FAIL in_data_done_pulse: got %b want 0", bus.in_done); end
    $display("txn IN: DATA sent, host ACK, in_done");
  endtask

  task automatic test_in_timeout();
    int n;
    bit seen;
    bit done_seen;
    bus.tx_data_ready = 1'b1; bus.ep_halt = 1'b0;
    send_pkt(4'b0001, 1'b0, 1'b0);
    repeat (2) tick();
    bus.tx_transfer_active = 1'b1;
    repeat (2) tick();
    tx_end();
    n = 0; seen = 1'b0; done_seen = 1'b0;
    for (int i = 1; i <= 300 && !seen; i++) begin
      tick();
      if (bus.in_done) done_seen = 1'b1;
      if (bus.txn_error) begin seen = 1'b1; n = i; end
    end
    compared++; if (n != 160) begin mismatched++; $display("FAIL in_timeout_cycles: got %0d want 160", n); end
    compared++; if (done_seen !== 1'b0) begin mismatched++; $display("FAIL in_timeout_no_done: got %b want 0", done_seen); end
    bus.tx_data_ready = 1'b0;
    tick();
    $display("txn IN: no host ACK, txn_error after %0d cycles", n);
  endtask

  task automatic test_halt();
    bus.ep_halt = 1'b1; bus.tx_data_ready = 1'b1; bus.rx_buffer_occupancy = 7'd0;
    send_pkt(4'b0001, 1'b0, 1'b0);
    repeat (2) tick();
    compared++; if (bus.tx_start !== 1'b1 || bus.tx_packet !== 3'b100) begin mismatched++; $display("FAIL halt_in: got start=%b pkt=%b want 1/100", bus.tx_start, bus.tx_packet); end
    bus.tx_transfer_active = 1'b1;
    repeat (2) tick();
    tx_end();
    send_pkt(4'b0010, 1'b0, 1'b0);
    tick();
    send_pkt(4'b0000, 1'b1, 1'b0);
    compared++; if (bus.flush !== 1'b1) begin mismatched++; $display("FAIL halt_out_flush: got %b want 1", bus.flush); end
    repeat (2) tick();
    compared++; if (bus.tx_start !== 1'b1 || bus.tx_packet !== 3'b100) begin mismatched++; $display("FAIL halt_out: got start=%b pkt=%b want 1/100", bus.tx_start, bus.tx_packet); end
    bus.tx_transfer_active = 1'b1;
    repeat (2) tick();
    tx_end();
    compared++; if (bus.out_done !== 1'b0) begin mismatched++; $display("FAIL halt_out_done: got %b want 0", bus.out_done); end
    bus.ep_halt = 1'b0; bus.tx_data_ready = 1'b0;
    $display("txn halted: STALL for IN and OUT");
  endtask

  task automatic test_out_errors();
    int n;
    bit seen;
    bit start_seen;
    send_pkt(4'b0010, 1'b0, 1'b0);
    tick();
    send_pkt(4'b0000, 1'b0, 1'b1);
    compared++; if (bus.flush !== 1'b1 || bus.txn_error !== 1'b1) begin mismatched++; $display("FAIL out_rxerr: got flush=%b txn_error=%b want 1/1", bus.flush, bus.txn_error); end
    start_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); if (bus.tx_start) start_seen = 1'b1; end
    compared++; if (start_seen !== 1'b0) begin mismatched++; $display("FAIL out_rxerr_no_start: got %b want 0", start_seen); end
    $display("txn OUT data rx_error: flush + txn_error");
    send_pkt(4'b0010, 1'b0, 1'b0);
    n = 0; seen = 1'b0;
    for (int i = 1; i <= 300 && !seen; i++) begin
      tick();
      if (bus.txn_error) begin
        seen = 1'b1; n = i;
        compared++; if (bus.flush !== 1'b1) begin mismatched++; $display("FAIL out_timeout_flush: got %b want 1", bus.flush); end
      end
    end
    compared++; if (n != 160) begin mismatched++; $display("FAIL out_timeout_cycles: got %0d want 160", n); end
    tick();
    $display("txn OUT silence: timeout after %0d cycles", n);
  endtask

  task automatic test_reset_mid_tx();
    bus.rx_buffer_occupancy = 7'd0;
    send_pkt(4'b0010, 1'b0, 1'b0);
    tick();
    send_pkt(4'b0000, 1'b1, 1'b0);
    repeat (2) tick();
    bus.tx_transfer_active = 1'b1;
    repeat (2) tick();
    compared++; if (bus.d_mode !== 1'b1) begin mismatched++; $display("FAIL rst_mid_busy: got d_mode=%b want 1", bus.d_mode); end
    n_rst = 1'b0;
    #1;
    compared++; if (bus.d_mode !== 1'b0 || bus.tx_packet !== 3'b000 || bus.flush !== 1'b0) begin mismatched++; $display("FAIL rst_mid_async: got d_mode=%b pkt=%b flush=%b want 0/000/0", bus.d_mode, bus.tx_packet, bus.flush); end
    bus.tx_transfer_active = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
    bus.tx_data_ready = 1'b0; bus.ep_halt = 1'b0;
    send_pkt(4'b0001, 1'b0, 1'b0);
    repeat (2) tick();
    compared++; if (bus.tx_start !== 1'b1 || bus.tx_packet !== 3'b011) begin mismatched++; $display("FAIL rst_mid_recover: got start=%b pkt=%b want 1/011", bus.tx_start, bus.tx_packet); end
    bus.tx_transfer_active = 1'b1;
    tick();
    tx_end();
    $display("txn reset mid TX_BUSY: recovered, IN answered NAK");
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_out_ack();
    test_out_nak();
    test_in_data();
    test_in_timeout();
    test_halt();
    test_out_errors();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
